orion_page_mapper: RTL and testbench

Parametrised memory page mapper for the Orion-Pro family. It generalises the fixed RAM0/RAM1/RAM2 window scheme to NUM_WIN equal-size CPU windows, each with its own page register, enable bit and write-protect bit. It adds a deferred-commit mode that switches all page registers together at an instruction boundary. It sits between the Z80 bus decode and the RAM address port.

---
 rtl/orion_mapper_pkg.sv | 32 +++
 rtl/orion_bus_strobe.sv | 33 +++
 rtl/orion_page_mapper.sv | 205 ++++++++++++++++++++
 tb/tb_orion_page_mapper.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/orion_mapper_pkg.sv
// Shared types and register-map helpers for the Orion-Pro page mapper.
// Readback is built only when ORION_MAPPER_READBACK_EN is defined.
package orion_mapper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_WAIT_M1,
    ST_IN_M1
  } mapper_state_t;

  localparam int CTRL_DEFER  = 0;
  localparam int CTRL_COMMIT = 1;
  localparam int CTRL_PEND   = 2;

  function automatic int off_en(input int nw);
    return nw;
  endfunction

  function automatic int off_wp(input int nw);
    return nw + 1;
  endfunction

  function automatic int off_ctrl(input int nw);
    return nw + 2;
  endfunction

  function automatic int blk_len(input int nw);
    return nw + 3;
  endfunction

endpackage

// File: rtl/orion_bus_strobe.sv
// One-shot accept: fires on the first matching clock of a strobe-low
// cycle and re-arms only once the strobe returns high.
module orion_bus_strobe (
  input  logic clk_i,
  input  logic reset_i,
  input  logic match_i,
  input  logic strobe_n_i,
  output logic accept_o
);

  logic armed_q;
  logic armed_d;

  assign accept_o = armed_q & match_i & ~strobe_n_i;

  // disarm after an accept, re-arm when the strobe goes inactive
  always_comb begin
    armed_d = armed_q;
    if (strobe_n_i)
      armed_d = 1'b1;
    else if (accept_o)
      armed_d = 1'b0;
  end

  // armed flag register
  always_ff @(posedge clk_i) begin
    if (reset_i)
      armed_q <= 1'b1;
    else
      armed_q <= armed_d;
  end

endmodule

// File: rtl/orion_page_mapper.sv
// NUM_WIN-window page mapper with shadow/active banks and M1 commit.
// Readback mux is built only when ORION_MAPPER_READBACK_EN is defined.
module orion_page_mapper
  import orion_mapper_pkg::*;
#(
  parameter int         NUM_WIN = 4,
  parameter int         PAGE_W  = 8,
  parameter logic [7:0] IO_BASE = 8'h04
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [15:0]            i_addr,
  input  logic [7:0]             i_wdata,
  input  logic                   i_iorq_n,
  input  logic                   i_mreq_n,
  input  logic                   i_rd_n,
  input  logic                   i_wr_n,
  input  logic                   i_m1_n,
  output logic [7:0]             o_rdata,
  output logic                   o_rdata_oe,
  output logic [PAGE_W+16-$clog2(NUM_WIN)-1:0] o_phys_addr,
  output logic [$clog2(NUM_WIN)-1:0] o_win_idx,
  output logic                   o_mapped,
  output logic                   o_wr_block
);

  localparam int WIDX_W = $clog2(NUM_WIN);
  localparam int WIN_SH = 16 - WIDX_W;

  logic [7:0]        io_off;
  logic              io_hit;
  logic              wr_acc;
  logic              sel_en;
  logic              sel_wp;
  logic              sel_ctrl;
  logic [PAGE_W-1:0] page_wr;
  logic [NUM_WIN-1:0] mask_wr;
  logic              commit;

  mapper_state_t state_q, state_d;

  logic [PAGE_W-1:0]  page_sh_q  [NUM_WIN];
  logic [PAGE_W-1:0]  page_sh_d  [NUM_WIN];
  logic [PAGE_W-1:0]  page_act_q [NUM_WIN];
  logic [PAGE_W-1:0]  page_act_d [NUM_WIN];
  logic [NUM_WIN-1:0] en_sh_q, en_sh_d;
  logic [NUM_WIN-1:0] en_act_q, en_act_d;
  logic [NUM_WIN-1:0] wp_sh_q, wp_sh_d;
  logic [NUM_WIN-1:0] wp_act_q, wp_act_d;
  logic               defer_q, defer_d;

  logic [WIDX_W-1:0] win;

  // I/O port decode relative to the register block base
  always_comb begin
    io_off   = i_addr[7:0] - IO_BASE;
    io_hit   = (i_addr[7:0] >= IO_BASE) &&
               (io_off < 8'(blk_len(NUM_WIN)));
    sel_en   = io_off == 8'(off_en(NUM_WIN));
    sel_wp   = io_off == 8'(off_wp(NUM_WIN));
    sel_ctrl = io_off == 8'(off_ctrl(NUM_WIN));
    page_wr  = PAGE_W'(i_wdata);
    mask_wr  = i_wdata[NUM_WIN-1:0];
  end

  orion_bus_strobe u_wr_strobe (
    .clk_i      (i_clk),
    .reset_i    (i_reset),
    .match_i    (~i_iorq_n & io_hit),
    .strobe_n_i (i_wr_n),
    .accept_o   (wr_acc)
  );

  // commit sequencing: OUT, end of OUT, next M1, end of M1
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE:
        if (wr_acc && sel_ctrl && i_wdata[CTRL_COMMIT])
          state_d = ST_ARMED;
      ST_ARMED:
        if (i_wr_n)
          state_d = ST_WAIT_M1;
      ST_WAIT_M1:
        if (!i_m1_n && !i_mreq_n)
          state_d = ST_IN_M1;
      ST_IN_M1:
        if (i_m1_n) begin
          state_d = ST_IDLE;
          commit  = 1'b1;
        end
      default:
        state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // bank updates: commit copies shadow, then an accepted write overlays
  always_comb begin
    page_sh_d  = page_sh_q;
    page_act_d = page_act_q;
    en_sh_d    = en_sh_q;
    en_act_d   = en_act_q;
    wp_sh_d    = wp_sh_q;
    wp_act_d   = wp_act_q;
    defer_d    = defer_q;
    if (commit) begin
      page_act_d = page_sh_q;
      en_act_d   = en_sh_q;
      wp_act_d   = wp_sh_q;
    end
    if (wr_acc) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        if (io_off == 8'(w)) begin
          page_sh_d[w] = page_wr;
          if (!defer_q)
            page_act_d[w] = page_wr;
        end
      end
      if (sel_en) begin
        en_sh_d = mask_wr;
        if (!defer_q)
          en_act_d = mask_wr;
      end
      if (sel_wp) begin
        wp_sh_d = mask_wr;
        if (!defer_q)
          wp_act_d = mask_wr;
      end
      if (sel_ctrl)
        defer_d = i_wdata[CTRL_DEFER];
    end
  end

  // register banks and CTRL
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        page_sh_q[w]  <= PAGE_W'(w);
        page_act_q[w] <= PAGE_W'(w);
      end
      en_sh_q  <= '0;
      en_act_q <= '0;
      wp_sh_q  <= '0;
      wp_act_q <= '0;
      defer_q  <= 1'b0;
    end else begin
      page_sh_q  <= page_sh_d;
      page_act_q <= page_act_d;
      en_sh_q    <= en_sh_d;
      en_act_q   <= en_act_d;
      wp_sh_q    <= wp_sh_d;
      wp_act_q   <= wp_act_d;
      defer_q    <= defer_d;
    end
  end

  // zero-latency address translation from the active bank
  always_comb begin
    win         = i_addr[15:WIN_SH];
    o_win_idx   = win;
    o_mapped    = en_act_q[win];
    o_phys_addr = '0;
    o_phys_addr[15:0] = i_addr;
    if (en_act_q[win])
      o_phys_addr = {page_act_q[win], i_addr[WIN_SH-1:0]};
    o_wr_block  = en_act_q[win] & wp_act_q[win] &
                  ~i_mreq_n & ~i_wr_n;
  end

`ifdef ORION_MAPPER_READBACK_EN
  // combinational readback of the active bank and CTRL
  always_comb begin
    o_rdata    = '0;
    o_rdata_oe = ~i_iorq_n & ~i_rd_n & io_hit;
    if (o_rdata_oe) begin
      for (int w = 0; w < NUM_WIN; w++)
        if (io_off == 8'(w))
          o_rdata = 8'(page_act_q[w]);
      if (sel_en)
        o_rdata = 8'(en_act_q);
      if (sel_wp)
        o_rdata = 8'(wp_act_q);
      if (sel_ctrl) begin
        o_rdata[CTRL_PEND]  = state_q != ST_IDLE;
        o_rdata[CTRL_DEFER] = defer_q;
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd  = i_rd_n;
  assign o_rdata    = '0;
  assign o_rdata_oe = 1'b0;
`endif

endmodule

// File: tb/tb_orion_page_mapper.sv
// Scoreboard bench for orion_page_mapper (default parameters).
// Ports: PAGE0..3 = 04..07, EN = 08, WP = 09, CTRL = 0A.
module tb_orion_page_mapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        iorq_n, mreq_n, rd_n, wr_n, m1_n;
  logic [7:0]  rdata;
  logic        oe;
  logic [21:0] pa;
  logic [1:0]  widx;
  logic        mapped;
  logic        blk;

  always #5 clk = ~clk;

  orion_page_mapper dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_iorq_n    (iorq_n),
    .i_mreq_n    (mreq_n),
    .i_rd_n      (rd_n),
    .i_wr_n      (wr_n),
    .i_m1_n      (m1_n),
    .o_rdata     (rdata),
    .o_rdata_oe  (oe),
    .o_phys_addr (pa),
    .o_win_idx   (widx),
    .o_mapped    (mapped),
    .o_wr_block  (blk)
  );

  typedef struct {
    string       name;
    bit          is_rd;
    logic [21:0] pa;
    logic [1:0]  widx;
    logic        mapped;
    logic        blk;
    logic [7:0]  rd;
    logic        oe;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // monitor: pop one expectation per falling edge and compare
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.is_rd) begin
        if (rdata !== e.rd || oe !== e.oe) begin
          errors++;
          $display("FAIL %s: rdata=%h oe=%b, expected rdata=%h oe=%b",
                   e.name, rdata, oe, e.rd, e.oe);
        end
      end else begin
        if (pa !== e.pa || widx !== e.widx || mapped !== e.mapped ||
            blk !== e.blk || oe !== 1'b0) begin
          errors++;
          $display("FAIL %s: pa=%h idx=%0d map=%b blk=%b oe=%b, expected pa=%h idx=%0d map=%b blk=%b oe=0",
                   e.name, pa, widx, mapped, blk, oe,
                   e.pa, e.widx, e.mapped, e.blk);
        end
      end
    end
  end

  task automatic idle();
    iorq_n = 1'b1;
    mreq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    m1_n   = 1'b1;
  endtask

  task automatic io_wr(input logic [7:0] port, input logic [7:0] d);
    addr   = {8'h00, port};
    wdata  = d;
    iorq_n = 1'b0;
    wr_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string n, input logic [7:0] port,
                        input logic [7:0] v);
    exp_t e;
    addr   = {8'h00, port};
    iorq_n = 1'b0;
    rd_n   = 1'b0;
    e.name  = n;
    e.is_rd = 1'b1;
    e.pa    = '0;
    e.widx  = '0;
    e.mapped = 1'b0;
    e.blk   = 1'b0;
`ifdef ORION_MAPPER_READBACK_EN
    e.rd    = v;
    e.oe    = 1'b1;
`else
    e.rd    = 8'h00;
    e.oe    = 1'b0;
    if (v === 8'hxx) e.rd = 8'h00;
`endif
    q.push_back(e);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push_map(input string n, input logic [15:0] a,
                          input logic [21:0] epa, input logic em,
                          input logic eb);
    exp_t e;
    e.name   = n;
    e.is_rd  = 1'b0;
    e.pa     = epa;
    e.widx   = a[15:14];
    e.mapped = em;
    e.blk    = eb;
    e.rd     = 8'h00;
    e.oe     = 1'b0;
    q.push_back(e);
  endtask

  task automatic map_chk(input string n, input logic [15:0] a,
                         input logic mrq, input logic wr,
                         input logic [21:0] epa, input logic em,
                         input logic eb);
    addr   = a;
    mreq_n = ~mrq;
    wr_n   = ~wr;
    rd_n   = ~(mrq & ~wr);
    push_map(n, a, epa, em, eb);
    @(posedge clk);
    #1;
    idle();
  endtask

  // opcode fetch held two clocks, then one idle clock for the commit edge
  task automatic m1_fetch(input string n, input logic [15:0] a,
                          input logic [21:0] epa, input logic em);
    addr   = a;
    mreq_n = 1'b0;
    rd_n   = 1'b0;
    m1_n   = 1'b0;
    push_map(n, a, epa, em, 1'b0);
    @(posedge clk);
    #1;
    push_map(n, a, epa, em, 1'b0);
    @(posedge clk);
    #1;
    idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    addr  = 16'h0000;
    wdata = 8'h00;
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    rd_chk("rst_page0", 8'h04, 8'h00);
    rd_chk("rst_page1", 8'h05, 8'h01);
    rd_chk("rst_page2", 8'h06, 8'h02);
    rd_chk("rst_page3", 8'h07, 8'h03);
    rd_chk("rst_en", 8'h08, 8'h00);
    rd_chk("rst_ctrl", 8'h0A, 8'h00);
    map_chk("rst_map", 16'h8123, 1'b0, 1'b0, 22'h008123, 1'b0, 1'b0);

    // immediate writes
    io_wr(8'h06, 8'h55);
    io_wr(8'h08, 8'h0F);
    map_chk("imm_w2", 16'h8010, 1'b0, 1'b0, 22'h154010, 1'b1, 1'b0);
    map_chk("imm_w1", 16'h4000, 1'b0, 1'b0, 22'h004000, 1'b1, 1'b0);
    map_chk("imm_w3", 16'hC010, 1'b0, 1'b0, 22'h00C010, 1'b1, 1'b0);

    // wr_n held low 3 clocks with changing data: only the first accepts
    addr   = 16'h0007;
    wdata  = 8'h11;
    iorq_n = 1'b0;
    wr_n   = 1'b0;
    @(posedge clk);
    #1;
    wdata = 8'h99;
    repeat (2) @(posedge clk);
    #1;
    idle();
    @(posedge clk);
    #1;
    map_chk("oneshot_map", 16'hC010, 1'b0, 1'b0, 22'h044010, 1'b1, 1'b0);
    rd_chk("oneshot_rd", 8'h07, 8'h11);

    // deferred writes and commit
    io_wr(8'h0A, 8'h01);
    io_wr(8'h05, 8'h22);
    io_wr(8'h08, 8'h02);
    map_chk("defer_old", 16'h4000, 1'b0, 1'b0, 22'h004000, 1'b1, 1'b0);
    rd_chk("defer_page1", 8'h05, 8'h01);
    rd_chk("defer_en", 8'h08, 8'h0F);
    io_wr(8'h0A, 8'h03);
    rd_chk("pend_set", 8'h0A, 8'h05);
    map_chk("pend_old", 16'h4000, 1'b0, 1'b0, 22'h004000, 1'b1, 1'b0);
    m1_fetch("m1_old", 16'h4000, 22'h004000, 1'b1);
    map_chk("commit_w1", 16'h4000, 1'b0, 1'b0, 22'h088000, 1'b1, 1'b0);
    map_chk("commit_w2", 16'h8010, 1'b0, 1'b0, 22'h008010, 1'b0, 1'b0);
    rd_chk("pend_clr", 8'h0A, 8'h01);
    rd_chk("commit_rd1", 8'h05, 8'h22);

    // write protect
    io_wr(8'h0A, 8'h00);
    io_wr(8'h08, 8'h04);
    io_wr(8'h09, 8'hF4);
    map_chk("wp_write", 16'h8000, 1'b1, 1'b1, 22'h154000, 1'b1, 1'b1);
    map_chk("wp_read", 16'h8000, 1'b1, 1'b0, 22'h154000, 1'b1, 1'b0);
    map_chk("wp_unmapped", 16'h4000, 1'b1, 1'b1, 22'h004000, 1'b0, 1'b0);
    rd_chk("wp_mask", 8'h09, 8'h04);

    // reset while waiting for M1
    io_wr(8'h0A, 8'h01);
    io_wr(8'h06, 8'h77);
    io_wr(8'h0A, 8'h03);
    rd_chk("pend_pre_rst", 8'h0A, 8'h05);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_chk("rst_mid_ctrl", 8'h0A, 8'h00);
    rd_chk("rst_mid_page2", 8'h06, 8'h02);
    rd_chk("rst_mid_en", 8'h08, 8'h00);
    map_chk("rst_mid_map", 16'h8000, 1'b0, 1'b0, 22'h008000, 1'b0, 1'b0);
    io_wr(8'h0A, 8'h01);
    io_wr(8'h08, 8'h04);
    m1_fetch("rst_m1", 16'h0000, 22'h000000, 1'b0);
    map_chk("no_commit", 16'h8000, 1'b0, 1'b0, 22'h008000, 1'b0, 1'b0);

    // double COMMIT, shadow changed before the M1
    io_wr(8'h08, 8'h0C);
    io_wr(8'h07, 8'h30);
    io_wr(8'h0A, 8'h03);
    io_wr(8'h0A, 8'h03);
    rd_chk("dbl_pend", 8'h0A, 8'h05);
    io_wr(8'h07, 8'h31);
    map_chk("dbl_before", 16'hC000, 1'b0, 1'b0, 22'h00C000, 1'b0, 1'b0);
    m1_fetch("dbl_m1", 16'h0000, 22'h000000, 1'b0);
    map_chk("dbl_w3", 16'hC000, 1'b0, 1'b0, 22'h0C4000, 1'b1, 1'b0);
    map_chk("dbl_w2", 16'h8000, 1'b0, 1'b0, 22'h008000, 1'b1, 1'b0);
    rd_chk("dbl_clr", 8'h0A, 8'h01);
    io_wr(8'h07, 8'h40);
    m1_fetch("dbl_m1b", 16'h0000, 22'h000000, 1'b0);
    map_chk("single_commit", 16'hC000, 1'b0, 1'b0, 22'h0C4000, 1'b1, 1'b0);
    rd_chk("single_rd", 8'h07, 8'h31);

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
